// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared types and defaults for the PLL lock supervisor
// Holds the supervisor state enum, default timing constants, the relock
// counter width and a helper to size the shared cycle counter.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABILIZE,
        RUN,
        FAULT
    } pll_state_t;

    localparam int DEF_SYNC_STAGES         = 2;
    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_STABLE_CYCLES       = 1000;
    localparam int RELOCK_W                = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit: N-flop synchroniser for one asynchronous bit
// Ports: clk (sampling clock), rst (async active-high, clears all flops),
//        d (asynchronous input), q (synchronised output after N flops).
module sync_bit #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ff <= '0;
        else
            ff <= {ff[N-2:0], d};
    end

    assign q = ff[N-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, qualifies lock and gates the system reset
// Ports: refclk (only clock), rst (async active-high), pll_locked (async PLL lock),
//        pll_rst (PLL reset), sys_rst (downstream reset), ready (high in RUN),
//        lock_lost (one-cycle pulse on RUN lock loss), relock_count (saturating
//        RUN-loss count), fault (sticky timeout flag, absent with the macro).
// Build option: PLL_SUP_AUTORETRY_EN makes a lock timeout retry the PLL reset
// instead of parking in FAULT.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int STABLE_CYCLES       = DEF_STABLE_CYCLES,
    parameter int CNT_W = $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES)) + 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    output logic                pll_rst,
    output logic                sys_rst,
    output logic                ready,
    output logic                lock_lost,
    output logic [RELOCK_W-1:0] relock_count
`ifdef PLL_SUP_AUTORETRY_EN
`else
    ,
    output logic                fault
`endif
);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STABLE_CYCLES - 1);

    pll_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             locked_sync;

    sync_bit #(.N(SYNC_STAGES)) u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_sync)
    );

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state        <= RESET_PLL;
            cnt          <= '0;
            lock_lost    <= 1'b0;
            relock_count <= '0;
        end else begin
            lock_lost <= 1'b0;
            case (state)
                RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else
                        cnt <= cnt + 1'b1;
                end
                WAIT_LOCK: begin
                    // lock takes priority over a coincident timeout
                    if (locked_sync) begin
                        state <= STABILIZE;
                        cnt   <= '0;
                    end else if (cnt == TO_LAST) begin
`ifdef PLL_SUP_AUTORETRY_EN
                        state <= RESET_PLL;
`else
                        state <= FAULT;
`endif
                        cnt   <= '0;
                    end else
                        cnt <= cnt + 1'b1;
                end
                STABILIZE: begin
                    if (!locked_sync) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == ST_LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else
                        cnt <= cnt + 1'b1;
                end
                RUN: begin
                    if (!locked_sync) begin
                        state     <= RESET_PLL;
                        cnt       <= '0;
                        lock_lost <= 1'b1;
                        if (relock_count != '1)
                            relock_count <= relock_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // outputs decode the state register only, so no input reaches them combinationally
    assign pll_rst = (state == RESET_PLL) || (state == FAULT);
    assign sys_rst = (state != RUN);
    assign ready   = (state == RUN);
`ifdef PLL_SUP_AUTORETRY_EN
`else
    assign fault   = (state == FAULT);
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: randomized scoreboard bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

    localparam int SS = 2, RP = 4, TO = 20, ST = 8;
    localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAULT = 4;

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic       lock_lost;
        logic       fault;
        logic [7:0] relock;
    } obs_t;

    logic       refclk = 1'b0;
    logic       rst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_rst, ready, lock_lost, fault;
    logic [7:0] relock_count;

    pll_lock_supervisor #(
        .SYNC_STAGES(SS), .RST_PULSE_CYCLES(RP),
        .LOCK_TIMEOUT_CYCLES(TO), .STABLE_CYCLES(ST)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready),
        .lock_lost(lock_lost), .relock_count(relock_count)
`ifdef PLL_SUP_AUTORETRY_EN
    );
    assign fault = 1'b0;
`else
        , .fault(fault)
    );
`endif

    always #5 refclk = ~refclk;

    obs_t exp_q[$];
    int   tests = 0, fails = 0;

    // reference model: phase plus cycles remaining in it, and the delay line of lock samples
    int   ph, rem, m_relock;
    bit   m_lost;
    bit   sq[$];

    function automatic obs_t m_out();
        obs_t o;
        o.pll_rst   = (ph == P_RST) || (ph == P_FAULT);
        o.sys_rst   = (ph != P_RUN);
        o.ready     = (ph == P_RUN);
        o.lock_lost = m_lost;
        o.fault     = (ph == P_FAULT);
        o.relock    = 8'(m_relock);
        return o;
    endfunction

    task automatic m_reset();
        ph = P_RST; rem = RP; m_relock = 0; m_lost = 0;
        sq = {};
        repeat (SS) sq.push_back(1'b0);
    endtask

    task automatic m_step(input bit lk);
        bit ls;
        ls = sq.pop_front();
        sq.push_back(lk);
        m_lost = 0;
        if (ph == P_RST) begin
            rem--;
            if (rem == 0) begin ph = P_WAIT; rem = TO; end
        end else if (ph == P_WAIT) begin
            if (ls) begin ph = P_STAB; rem = ST; end
            else begin
                rem--;
`ifdef PLL_SUP_AUTORETRY_EN
                if (rem == 0) begin ph = P_RST; rem = RP; end
`else
                if (rem == 0) ph = P_FAULT;
`endif
            end
        end else if (ph == P_STAB) begin
            if (!ls) begin ph = P_WAIT; rem = TO; end
            else begin
                rem--;
                if (rem == 0) ph = P_RUN;
            end
        end else if (ph == P_RUN && !ls) begin
            ph = P_RST; rem = RP; m_lost = 1;
            m_relock = (m_relock < 255) ? m_relock + 1 : 255;
        end
    endtask

    function automatic obs_t dut_obs();
        return {pll_rst, sys_rst, ready, lock_lost, fault, relock_count};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got pll_rst=%b sys_rst=%b ready=%b lock_lost=%b fault=%b relock=%0d, required pll_rst=%b sys_rst=%b ready=%b lock_lost=%b fault=%b relock=%0d",
                     name, $time, act.pll_rst, act.sys_rst, act.ready, act.lock_lost, act.fault, act.relock,
                     exp.pll_rst, exp.sys_rst, exp.ready, exp.lock_lost, exp.fault, exp.relock);
        end
    endtask

    task automatic check_cnt(input string name, input int exp);
        tests++;
        if (int'(relock_count) != exp) begin
            fails++;
            $display("FAIL %s: relock_count got %0d, required %0d", name, relock_count, exp);
        end
    endtask

    // monitor: every edge the DUT presents a new output set; compare with the oldest prediction
    initial forever begin
        @(posedge refclk);
        #2;
        if (exp_q.size() > 0) check("cycle", dut_obs(), exp_q.pop_front());
    end

    task automatic cyc(input bit lk, input bit r);
        @(negedge refclk);
        pll_locked = lk;
        rst = r;
        if (r) m_reset(); else m_step(lk);
        exp_q.push_back(m_out());
    endtask

    task automatic async_rst_mid(input bit lk);
        @(negedge refclk);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        check("async_rst", dut_obs(), m_out());
        exp_q.push_back(m_out());
        cyc(lk, 1'b1);
    endtask

    initial begin
        int run_len, fault_wait, g;
        bit cur;
        #1 rst = 1'b1;
        m_reset();
        repeat (3) cyc(1'b0, 1'b1);
        // power-up with no lock: pulse length, lock timeout, then retry or fault
        repeat (60) cyc(1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b1);

        run_len = 0; fault_wait = 0; cur = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run_len == 0) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 6)      begin cur = 1; run_len = $urandom_range(5, 40); end
                else if (r < 9) begin cur = 0; run_len = $urandom_range(1, 4); end
                else            begin cur = 0; run_len = $urandom_range(22, 45); end
            end
            if (ph == P_FAULT) begin
                if (fault_wait == 5) begin
                    cyc(cur, 1'b1); cyc(cur, 1'b1); fault_wait = 0;
                end else begin
                    fault_wait++; cyc(cur, 1'b0);
                end
            end else if (ph == P_STAB && rem == 4 && $urandom_range(0, 2) == 0)
                async_rst_mid(cur);
            else
                cyc(cur, 1'b0);
            run_len--;
        end

        // repeated RUN losses up to and past counter saturation
        repeat (2) cyc(1'b1, 1'b1);
        for (int k = 0; k < 300; k++) begin
            g = 0;
            while (ph != P_RUN && g < 60) begin cyc(1'b1, 1'b0); g++; end
            if (ph != P_RUN) begin
                tests++; fails++;
                $display("FAIL reach_run: model not in RUN after %0d cycles, required RUN", g);
            end
            repeat ($urandom_range(1, 3)) cyc(1'b0, 1'b0);
            g = 0;
            while (ph == P_RUN && g < 10) begin cyc(1'b1, 1'b0); g++; end
            if (k == 2) begin
                @(posedge refclk); #3;
                check_cnt("relock_after_3", 3);
            end
        end
        cyc(1'b1, 1'b0);
        @(posedge refclk); #3;
        check_cnt("relock_saturate", 255);
        repeat (3) @(posedge refclk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
